// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ----------------
// Decode/issue register between the IF/ID latch and the ALU execute stage.
// Accepts one 32-bit RV64 R-type word per cycle over valid/ready, reads the
// register file combinationally, and holds one decoded entry for execute.
// Supported ops: add, sub, xor, or, and. Anything else still issues, with
// ex_illegal set.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready/in_instr instruction handshake from IF/ID
//   rf_rs1_addr/rf_rs2_addr    regfile read addresses (comb from in_instr)
//   rf_rs1_data/rf_rs2_data    regfile read data (comb)
//   flush                      squash held and incoming instruction
//   ex_valid/ex_ready          issued entry handshake to execute
//   ex_funct3/7, ex_rs1/2, ex_rd, ex_illegal   registered entry fields
//   issued_count               accepted-instruction counter (wraps)
//
// Build option:
//   ALU_ISSUE_WB_BYPASS_EN     adds wb_en/wb_addr/wb_data; a writeback to a
//                              source register in the accept cycle is
//                              forwarded into the captured operand.

module alu_issue_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             flush,
`ifdef ALU_ISSUE_WB_BYPASS_EN
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
`endif
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic [XLEN-1:0]  ex_rs1,
    output logic [XLEN-1:0]  ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] issued_count
);

    typedef struct packed {
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OP_R = 7'b0110011;

    entry_t           entry_q, entry_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    entry_t           dec;

    // Anything outside the five supported opcode/funct combinations is
    // tagged illegal; the entry itself still flows to execute.
    function automatic logic is_illegal(input logic [31:0] instr);
        logic ok;
        ok = 1'b0;
        if (instr[6:0] == OP_R) begin
            case ({instr[31:25], instr[14:12]})
                {7'b0000000, 3'b000},
                {7'b0100000, 3'b000},
                {7'b0000000, 3'b100},
                {7'b0000000, 3'b110},
                {7'b0000000, 3'b111}: ok = 1'b1;
                default:              ok = 1'b0;
            endcase
        end
        return !ok;
    endfunction

    assign rf_rs1_addr = in_instr[19:15];
    assign rf_rs2_addr = in_instr[24:20];

    // A held entry blocks new work unless execute drains it this cycle;
    // flush blocks acceptance outright.
    assign in_ready = !flush && (!valid_q || ex_ready);
    assign accept   = in_valid && in_ready;

    // Operand select: x0 is hard zero, otherwise (optionally) a same-cycle
    // writeback to the same index wins over the stale regfile read.
    always_comb begin
        rs1_val = rf_rs1_data;
        rs2_val = rf_rs2_data;
`ifdef ALU_ISSUE_WB_BYPASS_EN
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rf_rs1_addr)) rs1_val = wb_data;
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rf_rs2_addr)) rs2_val = wb_data;
`endif
        if (rf_rs1_addr == 5'd0) rs1_val = '0;
        if (rf_rs2_addr == 5'd0) rs2_val = '0;
    end

    always_comb begin
        dec.funct7  = in_instr[31:25];
        dec.funct3  = in_instr[14:12];
        dec.rd      = in_instr[11:7];
        dec.rs1     = rs1_val;
        dec.rs2     = rs2_val;
        dec.illegal = is_illegal(in_instr);
    end

    // Flush dominates: it drops the held entry even if execute asserted
    // ex_ready in the same cycle, and no accept can occur.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            entry_d = dec;
            count_d = count_q + CNT_W'(1);
        end else if (valid_q && ex_ready) begin
            // Drain: data fields keep their last value.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_funct3    = entry_q.funct3;
    assign ex_funct7    = entry_q.funct7;
    assign ex_rs1       = entry_q.rs1;
    assign ex_rs2       = entry_q.rs2;
    assign ex_rd        = entry_q.rd;
    assign ex_illegal   = entry_q.illegal;
    assign issued_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage. Counter width is reduced so wrap-around
// can be reached by streaming accepts.
module tb_alu_issue_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            illegal;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = '0;
    logic [4:0]       rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data;
    logic             flush = 1'b0;
    logic             ex_valid;
    logic             ex_ready = 1'b0;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_funct7;
    logic [XLEN-1:0]  ex_rs1, ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_illegal;
    logic [CNT_W-1:0] issued_count;
`ifdef ALU_ISSUE_WB_BYPASS_EN
    logic             wb_en = 1'b0;
    logic [4:0]       wb_addr = '0;
    logic [XLEN-1:0]  wb_data = '0;
`endif

    logic [XLEN-1:0] regs [32];
    assign rf_rs1_data = regs[rf_rs1_addr];
    assign rf_rs2_data = regs[rf_rs2_addr];

    int n_run = 0;
    int n_fail = 0;

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .flush(flush),
`ifdef ALU_ISSUE_WB_BYPASS_EN
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
`endif
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_illegal(ex_illegal), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] r_instr(input logic [6:0] f7, input logic [4:0] rs2,
                                            input logic [4:0] rs1, input logic [2:0] f3,
                                            input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [XLEN-1:0] exp_op(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
`ifdef ALU_ISSUE_WB_BYPASS_EN
        if (wb_en && wb_addr == idx) return wb_data;
`endif
        return regs[idx];
    endfunction

    function automatic ent_t exp_entry(input logic [31:0] i);
        ent_t e;
        logic legal;
        legal = (i[6:0] == 7'b0110011) &&
                ((i[31:25] == 7'h00 && (i[14:12] == 3'd0 || i[14:12] == 3'd4 ||
                                        i[14:12] == 3'd6 || i[14:12] == 3'd7)) ||
                 (i[31:25] == 7'h20 && i[14:12] == 3'd0));
        e.funct7  = i[31:25];
        e.funct3  = i[14:12];
        e.rd      = i[11:7];
        e.rs1     = exp_op(i[19:15]);
        e.rs2     = exp_op(i[24:20]);
        e.illegal = !legal;
        return e;
    endfunction

    // Scoreboard: predicted entries are queued on accept and checked while
    // they sit on ex_*; model tracks valid and count independently.
    ent_t             exp_q[$];
    logic             m_valid;
    logic [CNT_W-1:0] m_count;
    logic             m_rdy, m_acc;
    ent_t             got;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_count = '0;
            exp_q.delete();
        end else begin
            m_rdy = !flush && (!m_valid || ex_ready);
            m_acc = in_valid && m_rdy;
            n_run++;
            if (in_ready !== m_rdy) begin
                n_fail++;
                $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, m_rdy, $time);
            end
            n_run++;
            if (ex_valid !== m_valid) begin
                n_fail++;
                $display("FAIL sb_ex_valid: got %b want %b at %0t", ex_valid, m_valid, $time);
            end
            if (m_valid && exp_q.size() > 0) begin
                got = {ex_funct7, ex_funct3, ex_rd, ex_rs1, ex_rs2, ex_illegal};
                n_run++;
                if (got !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL sb_entry: got %h want %h at %0t", got, exp_q[0], $time);
                end
            end
            n_run++;
            if (issued_count !== m_count) begin
                n_fail++;
                $display("FAIL sb_count: got %0d want %0d at %0t", issued_count, m_count, $time);
            end
            if (m_valid && (flush || ex_ready) && exp_q.size() > 0) void'(exp_q.pop_front());
            if (m_acc) begin
                exp_q.push_back(exp_entry(in_instr));
                m_count = m_count + 1'b1;
                m_valid = 1'b1;
            end else if (flush || ex_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({ex_valid, ex_illegal, ex_funct3, ex_funct7, ex_rd, ex_rs1, ex_rs2, issued_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b cnt=%0d rs1=%h", ex_valid, issued_count, ex_rs1);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_run++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_stream();
        regs[1] = 64'd5;
        regs[2] = 64'd7;
        ex_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        tick();
        in_instr = 32'h402081B3;
        #2;
        n_run++;
        if (!(ex_valid === 1'b1 && ex_rs1 === 64'd5 && ex_rs2 === 64'd7 && ex_rd === 5'd3 &&
              ex_funct3 === 3'd0 && ex_funct7 === 7'd0)) begin
            n_fail++;
            $display("FAIL stream_add: got v=%b rs1=%0d rs2=%0d rd=%0d f7=%h", ex_valid, ex_rs1, ex_rs2, ex_rd, ex_funct7);
        end
        tick();
        in_valid = 1'b0;
        #2;
        n_run++;
        if (ex_funct7 !== 7'h20 || issued_count !== 8'd2) begin
            n_fail++;
            $display("FAIL stream_sub: got f7=%h cnt=%0d want 20/2", ex_funct7, issued_count);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        a = r_instr(7'h00, 5'd2, 5'd1, 3'd4, 5'd9);
        b = r_instr(7'h00, 5'd1, 5'd2, 3'd6, 5'd10);
        ex_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = a;
        tick();
        in_instr = b;
        for (int k = 0; k < 3; k++) begin
            #2;
            n_run++;
            if (in_ready !== 1'b0 || ex_rd !== 5'd9 || ex_funct3 !== 3'd4 || ex_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold: got rdy=%b rd=%0d f3=%0d want 0/9/4", in_ready, ex_rd, ex_funct3);
            end
            tick();
        end
        ex_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        n_run++;
        if (ex_rd !== 5'd10 || ex_funct3 !== 3'd6) begin
            n_fail++;
            $display("FAIL stall_release: got rd=%0d f3=%0d want 10/6", ex_rd, ex_funct3);
        end
        tick();
        // Drain: valid drops, data holds.
        #2;
        n_run++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd10) begin
            n_fail++;
            $display("FAIL drain_hold: got v=%b rd=%0d want 0/10", ex_valid, ex_rd);
        end
    endtask

    task automatic test_illegal_x0();
        logic [CNT_W-1:0] c0;
        c0 = m_count;
        regs[0] = 64'hFFFF;
        ex_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h0020A1B3;
        tick();
        in_instr = r_instr(7'h00, 5'd2, 5'd0, 3'd0, 5'd3);
        #2;
        n_run++;
        if (ex_illegal !== 1'b1 || ex_valid !== 1'b1 || issued_count !== c0 + 8'd1) begin
            n_fail++;
            $display("FAIL illegal_slt: got ill=%b v=%b cnt=%0d", ex_illegal, ex_valid, issued_count);
        end
        tick();
        in_valid = 1'b0;
        #2;
        n_run++;
        if (ex_rs1 !== 64'd0 || ex_rs2 !== 64'd7 || ex_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_zero: got rs1=%h rs2=%h ill=%b want 0/7/0", ex_rs1, ex_rs2, ex_illegal);
        end
        tick();
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] c0;
        ex_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = r_instr(7'h00, 5'd2, 5'd1, 3'd7, 5'd4);
        tick();
        c0 = m_count;
        flush = 1'b1;
        ex_ready = 1'b1;
        in_instr = r_instr(7'h20, 5'd2, 5'd1, 3'd0, 5'd5);
        #2;
        n_run++;
        if (in_ready !== 1'b0 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: got rdy=%b v=%b want 0/1", in_ready, ex_valid);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #2;
        n_run++;
        if (ex_valid !== 1'b0 || issued_count !== c0) begin
            n_fail++;
            $display("FAIL flush_drop: got v=%b cnt=%0d want 0/%0d", ex_valid, issued_count, c0);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        ex_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = r_instr(7'h00, 5'd2, 5'd1, 3'd0, 5'd6);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_rs1 !== '0 || issued_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got v=%b rd=%0d cnt=%0d", ex_valid, ex_rd, issued_count);
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 1; r < 32; r++) regs[r] = {$urandom, $urandom};
        ex_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            in_instr = (k % 3 == 0) ? $urandom :
                       r_instr((k % 2) ? 7'h20 : 7'h00, 5'($urandom), 5'($urandom),
                               3'($urandom), 5'($urandom));
            tick();
            if (k == 254) begin
                #2;
                n_run++;
                if (issued_count !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL wrap_max: got %0d want 255", issued_count);
                end
            end
        end
        in_valid = 1'b0;
        #2;
        n_run++;
        if (issued_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %0d want 0", issued_count);
        end
        tick();
    endtask

`ifdef ALU_ISSUE_WB_BYPASS_EN
    task automatic test_bypass();
        regs[1] = 64'h11;
        regs[2] = 64'h22;
        wb_en = 1'b1;
        wb_addr = 5'd1;
        wb_data = 64'hAA;
        ex_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = r_instr(7'h00, 5'd1, 5'd1, 3'd0, 5'd3);
        tick();
        in_instr = r_instr(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        #2;
        n_run++;
        if (ex_rs1 !== 64'hAA || ex_rs2 !== 64'hAA) begin
            n_fail++;
            $display("FAIL bypass_both: got rs1=%h rs2=%h want aa/aa", ex_rs1, ex_rs2);
        end
        tick();
        in_valid = 1'b0;
        wb_en = 1'b0;
        #2;
        n_run++;
        if (ex_rs1 !== 64'hAA || ex_rs2 !== 64'h22) begin
            n_fail++;
            $display("FAIL bypass_rs1: got rs1=%h rs2=%h want aa/22", ex_rs1, ex_rs2);
        end
        tick();
    endtask
`endif

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = '0;
        do_reset();
        test_reset();
        test_stream();
        test_stall();
        test_illegal_x0();
        test_flush();
        test_reset_mid_stall();
        test_wrap();
`ifdef ALU_ISSUE_WB_BYPASS_EN
        test_bypass();
`endif
        tick();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline register that sits between the IF/ID latch and the execute stage.
- Accepts 32-bit RV64 R-type instructions over a valid/ready handshake, decodes them, reads the register file, and presents registered funct3/funct7/operand/destination fields to the ALU.
- Single-entry buffer with back-pressure, flush, illegal-op tagging and an issue counter.

Parameters:
- XLEN, 64, operand width.
- CNT_W, 32, width of issued-instruction counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction word valid from IF/ID
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  instruction word
- rf_rs1_addr  output  5  regfile read address 1, combinational = in_instr[19:15]
- rf_rs2_addr  output  5  regfile read address 2, combinational = in_instr[24:20]
- rf_rs1_data  input  XLEN  regfile read data 1, combinational
- rf_rs2_data  input  XLEN  regfile read data 2, combinational
- flush  input  1  squash held and incoming instruction
- ex_valid  output  1  issued entry valid to execute
- ex_ready  input  1  execute consumes entry this cycle
- ex_funct3  output  3  registered funct3
- ex_funct7  output  7  registered funct7
- ex_rs1  output  XLEN  registered operand 1
- ex_rs2  output  XLEN  registered operand 2
- ex_rd  output  5  registered destination index
- ex_illegal  output  1  entry is not a supported R-type op
- issued_count  output  CNT_W  count of accepted instructions

Behaviour:
- Reset (rst_n low, async): ex_valid=0, all ex_* data outputs=0, ex_illegal=0, issued_count=0. in_ready=1 immediately after release.
- in_ready = !flush && (!ex_valid || ex_ready); combinational.
- Accept = in_valid && in_ready. On accept, next edge: ex_valid=1, capture funct3=[14:12], funct7=[31:25], rd=[11:7], operands.
- Operands: address 0 yields 0 regardless of rf data.
- Latency: accepted instruction visible on ex_* one cycle after acceptance.
- Full throughput: back-to-back accept when ex_ready=1 every cycle.
- Drain: ex_valid && ex_ready && !accept -> ex_valid=0 next edge; data outputs hold last value.
- Stall: ex_valid && !ex_ready -> all ex_* hold, in_ready=0.
- Flush (highest priority): next edge ex_valid=0, no accept that cycle, issued_count unchanged.
- Flush while ex_ready=1 still drops the entry; execute must not treat that cycle as a consume.
- ex_illegal=1 unless opcode [6:0]==0110011 and {funct7,funct3} is one of:
  - 0000000/000 (add)
  - 0100000/000 (sub)
  - 0000000/100 (xor)
  - 0000000/110 (or)
  - 0000000/111 (and)
- Illegal entries still issue normally with ex_illegal=1.
- issued_count increments by 1 per accept, including illegal entries; wraps 2^CNT_W-1 -> 0.
- Reset mid-stall discards the entry; no partial state survives.

Optional Feature:
- Macro ALU_ISSUE_WB_BYPASS_EN adds ports wb_en (1 in), wb_addr (5 in), wb_data (XLEN in).
- With macro: on accept, if wb_en && wb_addr!=0 && wb_addr==rs1 index, capture wb_data instead of rf_rs1_data; same for rs2. Both operands may bypass in the same cycle.
- Without macro: ports absent; operands always come from rf_*_data (x0 still forced 0).

Test Plan:
- Reset: hold rst_n=0 mid-cycle -> ex_valid=0, issued_count=0, in_ready=1 after release.
- Stream: instr 0x002081B3 (add x3,x1,x2), x1=5, x2=7, ex_ready=1 -> next cycle ex_valid=1, funct3=0, funct7=0, rs1=5, rs2=7, rd=3; then 0x402081B3 -> funct7=0x20; count=2.
- Stall: ex_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ex_* stable; after ex_ready=1, next instr issues the following cycle.
- Illegal and x0: instr 0x0020A1B3 (slt) -> ex_illegal=1, still counted; add x3,x0,x2 with rf_rs1_data=0xFFFF -> ex_rs1=0.
- Flush: flush=1 while ex_valid=1 and in_valid=1 -> ex_valid=0 next cycle, count unchanged, in_ready=0 during flush.
- Wrap/bypass: preload count to 0xFFFFFFFF, accept -> 0. With ALU_ISSUE_WB_BYPASS_EN, wb_en=1, wb_addr=1, wb_data=0xAA, rf_rs1_data=0x11 -> ex_rs1=0xAA.
